// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the pipeline core's memory responders (data side and
// instruction side):
//   - mem_state_e  : responder FSM states (IDLE / BUSY / DONE)
//   - CNT_W        : width of the access-latency down-counter
//   - ERR_*        : error-cause bit constants, OR-ed into a cause vector
//   - access_err() : classifies a request into its error causes
// -----------------------------------------------------------------------------
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  // Latency counter width; holds LATENCY values 1..15.
  localparam int CNT_W = 4;

  // Error-cause vector, one bit per cause.
  localparam int ERR_W = 3;
  localparam logic [ERR_W-1:0] ERR_NONE     = 3'b000;
  localparam logic [ERR_W-1:0] ERR_MISALIGN = 3'b001;  // byte offset not zero
  localparam logic [ERR_W-1:0] ERR_RANGE    = 3'b010;  // bits above the RAM set
  localparam logic [ERR_W-1:0] ERR_RW_BOTH  = 3'b100;  // read and write together

  // Causes that make an access illegal (no RAM write, zero read data).
  localparam logic [ERR_W-1:0] ERR_ILLEGAL_MASK = ERR_MISALIGN | ERR_RANGE;

  // Classify a request. addr_w is the responder's word-address width; any set
  // bit at or above byte-address bit addr_w+2 falls outside the RAM.
  function automatic logic [ERR_W-1:0] access_err(
    input logic [31:0] addr,
    input logic        ren,
    input logic        wen,
    input int unsigned addr_w
  );
    logic [ERR_W-1:0] cause;
    cause = ERR_NONE;
    if (addr[1:0] != 2'b00)                cause = cause | ERR_MISALIGN;
    if ((addr >> (addr_w + 2)) != 32'd0)   cause = cause | ERR_RANGE;
    if (ren && wen)                        cause = cause | ERR_RW_BOTH;
    return cause;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// -----------------------------------------------------------------------------
// dmem_ram
// Single-port synchronous word RAM with a registered read port.
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-low reset (read register only)
//   en     in   access enable for this cycle
//   we     in   1 = write wdata at addr, 0 = read addr into rdata
//   addr   in   word address, ADDR_W bits
//   wdata  in   write data, 32 bits
//   rdata  out  read data, updated on the edge after a read access
// -----------------------------------------------------------------------------
module dmem_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // NOTE: the storage array is deliberately not reset so it maps onto RAM
  // macros; only the output register is reset. Sequential state always uses
  // non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mips_dmem_responder.sv
// -----------------------------------------------------------------------------
// mips_dmem_responder
// Memory-side responder for the core's data port. Each word request is latched
// in IDLE, held for LATENCY BUSY cycles, serviced from dmem_ram at the end of
// the last BUSY cycle, and presented for one DONE cycle. mem_stall holds the
// core while its request is pending.
//
// Parameters
//   ADDR_W   word-address width (RAM depth 2**ADDR_W words)
//   LATENCY  BUSY cycles per access, legal range 1..15
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   mem_ren    in   read request (held while stalled)
//   mem_wen    in   write request (held while stalled)
//   mem_addr   in   byte address
//   mem_dout   in   write data from the core
//   mem_din    out  read data, valid in DONE, 0 otherwise
//   mem_stall  out  combinational: request pending and not in DONE
//   mem_err    out  sticky error (misaligned / out of range / ren&wen)
//
// Build option
//   DMEM_LAST_HIT_EN  one-entry last-access tag; a legal read matching the tag
//                     goes IDLE->DONE with the tagged data.
// -----------------------------------------------------------------------------
module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err
);

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mem_state_e        state;
  logic [CNT_W-1:0]  cnt;

  // Request latched on acceptance in IDLE.
  logic [ADDR_W-1:0] lat_idx;
  logic [31:0]       lat_data;
  logic              lat_write;
  logic              lat_illegal;

  // Incoming request decode.
  logic              req;
  logic [ADDR_W-1:0] req_idx;
  logic [ERR_W-1:0]  req_err;
  logic              req_illegal;

  // RAM port.
  logic              access_end;
  logic              ram_en;
  logic [31:0]       ram_rdata;

  // rd_valid: the RAM read register holds this access's data (legal read).
  // hit_done: the current DONE came from a tag hit, not from the RAM.
  logic              rd_valid;
  logic              hit;
  logic              hit_done;
  logic [31:0]       hit_data;

  assign req         = mem_ren | mem_wen;
  assign req_idx     = mem_addr[ADDR_W+1:2];
  assign req_err     = access_err(mem_addr, mem_ren, mem_wen, ADDR_W);
  assign req_illegal = |(req_err & ERR_ILLEGAL_MASK);

  // The RAM access happens on the edge that leaves the final BUSY cycle, so
  // the registered read data is ready exactly in DONE. Illegal accesses still
  // wait out the latency but never touch the RAM.
  assign access_end = (state == BUSY) && (cnt == CNT_ONE);
  assign ram_en     = access_end && !lat_illegal;

  dmem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (ram_en),
    .we    (lat_write),
    .addr  (lat_idx),
    .wdata (lat_data),
    .rdata (ram_rdata)
  );

`ifdef DMEM_LAST_HIT_EN
  logic              tag_valid;
  logic [ADDR_W-1:0] tag_idx;
  logic [31:0]       tag_data;

  // Only a plain legal read may bypass the latency; writes always go to RAM.
  assign hit = (state == IDLE) && mem_ren && !mem_wen && !req_illegal &&
               tag_valid && (tag_idx == req_idx);
  assign hit_data = tag_data;

  // Refresh the tag in DONE of every legal RAM access. A read's data is only
  // available from the RAM register at this point; a write uses the latched
  // data so the entry never goes stale after a write to the tagged word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_valid <= 1'b0;
      tag_idx   <= '0;
      tag_data  <= '0;
    end else if ((state == DONE) && !hit_done && !lat_illegal) begin
      tag_valid <= 1'b1;
      tag_idx   <= lat_idx;
      tag_data  <= lat_write ? lat_data : ram_rdata;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_idx     <= '0;
      lat_data    <= '0;
      lat_write   <= 1'b0;
      lat_illegal <= 1'b0;
      rd_valid    <= 1'b0;
      hit_done    <= 1'b0;
      mem_err     <= 1'b0;
    end else begin
      rd_valid <= ram_en && !lat_write;
      case (state)
        IDLE: begin
          if (req) begin
            lat_idx     <= req_idx;
            lat_data    <= mem_dout;
            lat_write   <= mem_wen;
            lat_illegal <= req_illegal;
            hit_done    <= hit;
            if (req_err != ERR_NONE) begin
              mem_err <= 1'b1;
            end
            if (hit) begin
              state <= DONE;
            end else begin
              cnt   <= LAT_CNT;
              state <= BUSY;
            end
          end
        end
        // The access completes even if the core drops its request (flush).
        BUSY: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_stall = req && (state != DONE);

  always_comb begin
    mem_din = '0;
    if (state == DONE) begin
      if (hit_done) begin
        mem_din = hit_data;
      end else if (rd_valid) begin
        mem_din = ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_mips_dmem_responder
// Self-checking bench for mips_dmem_responder. A reference model (word map,
// sticky error flag, last-access tag) predicts read data, stall length and
// mem_err for each access from the responder's rules. Inputs change 1 ns after
// the rising edge; outputs are sampled on the falling edge.
// With DMEM_LAST_HIT_EN defined the DUT runs with LATENCY=4 and the tag rules.
// -----------------------------------------------------------------------------
module tb_mips_dmem_responder;

  localparam int ADDR_W = 10;
`ifdef DMEM_LAST_HIT_EN
  localparam int LATENCY = 4;
  localparam bit HIT_EN  = 1'b1;
`else
  localparam int LATENCY = 2;
  localparam bit HIT_EN  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_ren = 1'b0;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_dout = '0;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        mem_err;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [31:0] model_mem [int];
  logic        model_err = 1'b0;
  logic        tag_valid = 1'b0;
  int          tag_idx   = 0;

  always #5 clk = ~clk;

  mips_dmem_responder #(
    .ADDR_W  (ADDR_W),
    .LATENCY (LATENCY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .mem_stall (mem_stall),
    .mem_err   (mem_err)
  );

  // One complete access, starting at posedge+1 with the DUT idle and ending
  // at posedge+1 of the cycle after DONE with the request removed.
  task automatic do_access(input logic ren, input logic wen,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input string name);
    logic        illegal, hit, done, din_bad, have_exp, got_err;
    int          idx, exp_stalls, stalls;
    logic [31:0] exp_din, got_din;

    illegal  = (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'd0);
    idx      = int'(addr[ADDR_W+1:2]);
    hit      = HIT_EN && ren && !wen && !illegal && tag_valid && (tag_idx == idx);
    exp_stalls = hit ? 1 : LATENCY + 1;
    have_exp = 1'b1;
    if (wen || illegal)              exp_din = 32'd0;
    else if (model_mem.exists(idx))  exp_din = model_mem[idx];
    else begin exp_din = 32'd0; have_exp = 1'b0; end
    if (illegal || (ren && wen)) model_err = 1'b1;
    if (wen && !illegal) model_mem[idx] = wdata;
    if (!illegal) begin tag_valid = 1'b1; tag_idx = idx; end

    mem_ren  = ren;
    mem_wen  = wen;
    mem_addr = addr;
    mem_dout = wdata;
    stalls = 0; done = 1'b0; din_bad = 1'b0; got_din = '0; got_err = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (mem_stall === 1'b1) begin
        stalls++;
        if (mem_din !== 32'd0) din_bad = 1'b1;
      end else begin
        got_din = mem_din;
        got_err = mem_err;
        done    = 1'b1;
      end
    end

    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s timeout: no DONE within 64 cycles (stall=%b)", name, mem_stall);
    end
    checks++;
    if (stalls !== exp_stalls) begin
      failures++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_stalls);
    end
    checks++;
    if (din_bad) begin
      failures++;
      $display("FAIL %s din_while_stalled: got nonzero expected 0", name);
    end
    if (have_exp) begin
      checks++;
      if (got_din !== exp_din) begin
        failures++;
        $display("FAIL %s mem_din: got %h expected %h", name, got_din, exp_din);
      end
    end
    checks++;
    if (got_err !== model_err) begin
      failures++;
      $display("FAIL %s mem_err: got %b expected %b", name, got_err, model_err);
    end

    @(posedge clk);
    #1;
    mem_ren = 1'b0;
    mem_wen = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (mem_din !== 32'd0) begin failures++; $display("FAIL reset mem_din: got %h expected 0", mem_din); end
    checks++;
    if (mem_err !== 1'b0) begin failures++; $display("FAIL reset mem_err: got %b expected 0", mem_err); end
    checks++;
    if (mem_stall !== 1'b0) begin failures++; $display("FAIL reset stall_idle: got %b expected 0", mem_stall); end
    mem_ren = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_stall !== 1'b1) begin failures++; $display("FAIL reset stall_eq_req: got %b expected 1", mem_stall); end
    mem_ren = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    do_access(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, "wr40");
    do_access(1'b1, 1'b0, 32'h40, 32'h0, "rd40");
  endtask

  task automatic test_misaligned();
    do_access(1'b1, 1'b0, 32'h41, 32'h0, "rd41_misaligned");
    do_access(1'b0, 1'b1, 32'h41, 32'hBAD0BAD0, "wr41_misaligned");
    do_access(1'b1, 1'b0, 32'h40, 32'h0, "rd40_after_misaligned");
    do_access(1'b1, 1'b0, 32'h1000, 32'h0, "rd_out_of_range");
  endtask

  task automatic test_both_set();
    do_access(1'b1, 1'b1, 32'h8, 32'h12345678, "rw8_both");
    do_access(1'b1, 1'b0, 32'h8, 32'h0, "rd8");
  endtask

  task automatic test_reset_mid_busy();
    do_access(1'b0, 1'b1, 32'h10, 32'hA5A50010, "wr10_old");
    mem_wen  = 1'b1;
    mem_addr = 32'h10;
    mem_dout = 32'hFFFF0000;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (mem_din !== 32'd0) begin failures++; $display("FAIL midrst mem_din: got %h expected 0", mem_din); end
    checks++;
    if (mem_stall !== 1'b1) begin failures++; $display("FAIL midrst stall_eq_req: got %b expected 1", mem_stall); end
    mem_wen = 1'b0;
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin failures++; $display("FAIL midrst stall_noreq: got %b expected 0", mem_stall); end
    checks++;
    if (mem_err !== 1'b0) begin failures++; $display("FAIL midrst mem_err: got %b expected 0", mem_err); end
    model_err = 1'b0;
    tag_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_access(1'b1, 1'b0, 32'h10, 32'h0, "rd10_after_rst");
  endtask

  task automatic test_flush();
    mem_wen  = 1'b1;
    mem_addr = 32'h20;
    mem_dout = 32'h00000055;
    model_mem[8] = 32'h00000055;
    tag_valid = 1'b1;
    tag_idx   = 8;
    @(posedge clk);
    #1;
    mem_wen = 1'b0;
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin failures++; $display("FAIL flush stall_drop: got %b expected 0", mem_stall); end
    repeat (LATENCY + 2) @(posedge clk);
    #1;
    do_access(1'b1, 1'b0, 32'h20, 32'h0, "rd20_after_flush");
  endtask

  task automatic test_last_hit();
    do_access(1'b0, 1'b1, 32'h80, 32'hC0DE0080, "hit_wr80");
    do_access(1'b0, 1'b1, 32'h84, 32'hC0DE0084, "hit_wr84");
    do_access(1'b1, 1'b0, 32'h80, 32'h0, "hit_rd80_miss");
    do_access(1'b1, 1'b0, 32'h80, 32'h0, "hit_rd80_hit");
    do_access(1'b1, 1'b0, 32'h84, 32'h0, "hit_rd84_miss");
    do_access(1'b0, 1'b1, 32'h84, 32'h11112222, "hit_wr84_refresh");
    do_access(1'b1, 1'b0, 32'h84, 32'h0, "hit_rd84_after_wr");
  endtask

  // Back-to-back random traffic over a 16-word pool plus illegal addresses.
  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      do_access(1'b0, 1'b1, 32'h100 + 32'(i * 4), $urandom, "rnd_prefill");
    end
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int kind;
      a = 32'h100 + 32'($urandom_range(15, 0) * 4);
      kind = $urandom_range(9, 0);
      case (kind)
        0: do_access(1'b1, 1'b0, a | 32'($urandom_range(3, 1)), 32'h0, "rnd_misaligned");
        1: do_access($urandom_range(1, 0) == 1, 1'b1,
                     a | (32'd1 << $urandom_range(31, ADDR_W + 2)), $urandom, "rnd_range");
        2: do_access(1'b1, 1'b1, a, $urandom, "rnd_both");
        3, 4, 5: do_access(1'b0, 1'b1, a, $urandom, "rnd_write");
        default: do_access(1'b1, 1'b0, a, 32'h0, "rnd_read");
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_misaligned();
    test_both_set();
    test_reset_mid_busy();
    test_flush();
    if (HIT_EN) test_last_hit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
